// File: rtl/cobra_pkg.sv
// Shared definitions for cobra_core: instruction field positions, ALU opcodes,
// write-source encodings and FSM states. WAIT_IN exists only with COBRA_IN_PORT_EN.
package cobra_pkg;

  localparam int J_BIT   = 31;
  localparam int B_BIT   = 30;
  localparam int WS_MSB  = 29;
  localparam int WS_LSB  = 28;
  localparam int OP_MSB  = 27;
  localparam int OP_LSB  = 23;
  localparam int RA1_MSB = 22;
  localparam int RA1_LSB = 18;
  localparam int RA2_MSB = 17;
  localparam int RA2_LSB = 13;
  localparam int C_MSB   = 12;
  localparam int C_LSB   = 5;
  localparam int WA_MSB  = 4;
  localparam int WA_LSB  = 0;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_SLT  = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_EQ   = 5'b11000;
  localparam logic [4:0] ALU_NE   = 5'b11001;
  localparam logic [4:0] ALU_LT   = 5'b11100;
  localparam logic [4:0] ALU_GE   = 5'b11101;
  localparam logic [4:0] ALU_LTU  = 5'b11110;
  localparam logic [4:0] ALU_GEU  = 5'b11111;

  localparam logic [1:0] WS_IN    = 2'b00;
  localparam logic [1:0] WS_ALU   = 2'b01;
  localparam logic [1:0] WS_CONST = 2'b10;
  localparam logic [1:0] WS_NONE  = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXEC    = 2'd1,
`ifdef COBRA_IN_PORT_EN
    ST_WAIT_IN = 2'd2,
`endif
    ST_HALT    = 2'd3
  } state_t;

  function automatic logic is_cmp(input logic [4:0] op);
    return op[4:3] == 2'b11;
  endfunction

endpackage

// File: rtl/cobra_alu.sv
// Combinational ALU for cobra_core; compare ops (11xxx) raise flag and return it
// zero-extended, undefined opcodes return 0.
module cobra_alu
  import cobra_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            flag
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = b[4:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    result = '0;
    flag   = 1'b0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = XLEN'($signed(a) >>> shamt);
      ALU_SLT:  result = XLEN'(lt_s);
      ALU_SLTU: result = XLEN'(lt_u);
      ALU_XOR:  result = a ^ b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_EQ:   flag = (a == b);
      ALU_NE:   flag = (a != b);
      ALU_LT:   flag = lt_s;
      ALU_GE:   flag = !lt_s;
      ALU_LTU:  flag = lt_u;
      ALU_GEU:  flag = !lt_u;
      default:  ;
    endcase
    if (is_cmp(op)) result = XLEN'(flag);
  end

endmodule

// File: rtl/cobra_core.sv
// Multi-cycle FETCH/EXEC core with x0, halt, out_data and retire strobe.
// Define COBRA_IN_PORT_EN to make WS=00 read in_data through a valid/ready handshake.
module cobra_core
  import cobra_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic [XLEN-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] out_data,
  output logic            halted,
  output logic            retired
);

  state_t          state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic [XLEN-1:0] rf [32];

  logic            j, b;
  logic [1:0]      ws;
  logic [4:0]      op, ra1, ra2, wa;
  logic [7:0]      c;
  logic [XLEN-1:0] c_x, rd1, rd2, alu_result;
  logic [PC_W-1:0] c_pc;
  logic            flag, taken, halting;

  logic            rf_we, out_we;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;

  assign j   = imem_rdata[J_BIT];
  assign b   = imem_rdata[B_BIT];
  assign ws  = imem_rdata[WS_MSB:WS_LSB];
  assign op  = imem_rdata[OP_MSB:OP_LSB];
  assign ra1 = imem_rdata[RA1_MSB:RA1_LSB];
  assign ra2 = imem_rdata[RA2_MSB:RA2_LSB];
  assign c   = imem_rdata[C_MSB:C_LSB];
  assign wa  = imem_rdata[WA_MSB:WA_LSB];

  assign c_x  = XLEN'($signed(c));
  assign c_pc = PC_W'($signed(c));

  // rf[0] is never written and resets to 0, so x0 needs no read-side mux.
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  cobra_alu #(.XLEN(XLEN)) u_alu (
    .op     (op),
    .a      (rd1),
    .b      (rd2),
    .result (alu_result),
    .flag   (flag)
  );

  assign taken   = j | (b & flag);
  assign halting = taken && (c == 8'd0);

`ifdef COBRA_IN_PORT_EN
  logic [4:0] wait_wa;
  logic       wait_cap;
  assign in_ready = (state == ST_WAIT_IN);
`else
  logic unused_in;
  assign unused_in = ^{in_data, in_valid};
  assign in_ready  = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    rf_we      = 1'b0;
    rf_wa      = wa;
    rf_wd      = alu_result;
    out_we     = 1'b0;
    retired    = 1'b0;
`ifdef COBRA_IN_PORT_EN
    wait_cap   = 1'b0;
`endif
    case (state)
      ST_FETCH: state_next = ST_EXEC;
      ST_EXEC: begin
`ifdef COBRA_IN_PORT_EN
        if (ws == WS_IN) begin
          state_next = ST_WAIT_IN;
          wait_cap   = 1'b1;
        end else
`endif
        begin
          retired    = 1'b1;
          pc_next    = taken ? pc + c_pc : pc + PC_W'(1);
          state_next = halting ? ST_HALT : ST_FETCH;
          case (ws)
            WS_ALU: begin
              rf_we  = 1'b1;
              out_we = 1'b1;
            end
            WS_CONST: begin
              rf_we = 1'b1;
              rf_wd = c_x;
            end
            WS_IN, WS_NONE: ;
            default: ;
          endcase
        end
      end
`ifdef COBRA_IN_PORT_EN
      ST_WAIT_IN: begin
        if (in_valid) begin
          rf_we      = 1'b1;
          rf_wa      = wait_wa;
          rf_wd      = in_data;
          pc_next    = pc + PC_W'(1);
          retired    = 1'b1;
          state_next = ST_FETCH;
        end
      end
`endif
      ST_HALT: ;
      default: state_next = ST_FETCH;
    endcase
  end

  // NOTE: the register file is reset because software relies on all registers starting at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FETCH;
      pc       <= '0;
      out_data <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
`ifdef COBRA_IN_PORT_EN
      wait_wa  <= '0;
`endif
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (out_we) out_data <= alu_result;
      if (rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
`ifdef COBRA_IN_PORT_EN
      if (wait_cap) wait_wa <= wa;
`endif
    end
  end

  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_cobra_core.sv
// Self-checking bench for cobra_core: a reference ISA model fills a scoreboard
// from the program image; each retire pops and checks pc, latency and results.
module tb_cobra_core;

  localparam int XLEN    = 32;
  localparam int PC_W    = 8;
  localparam int IN_WAIT = 5;
  localparam logic [31:0] IN_WORD = 32'h0000_ABCD;

  logic            clk = 1'b0;
  logic            rst;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [XLEN-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] out_data;
  logic            halted;
  logic            retired;

  cobra_core #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [256];
  always @(posedge clk) imem_rdata <= imem[imem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic j, input logic b, input logic [1:0] ws,
                                      input logic [4:0] op, input logic [4:0] ra1,
                                      input logic [4:0] ra2, input logic [7:0] c,
                                      input logic [4:0] wa);
    return {j, b, ws, op, ra1, ra2, c, wa};
  endfunction

  typedef struct {
    logic [7:0]  pc;
    logic [7:0]  next_pc;
    logic [31:0] out;
    int          lat;
    int          waits;
    logic        halt;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] halt_pc;

  function automatic logic [31:0] m_alu(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, output logic f);
    logic signed [31:0] sa, sbv;
    sa  = a;
    sbv = b;
    f   = 1'b0;
    case (op)
      5'b00000: return a + b;
      5'b01000: return a - b;
      5'b00001: return a << b[4:0];
      5'b00101: return a >> b[4:0];
      5'b01101: return sa >>> b[4:0];
      5'b00010: return (sa < sbv) ? 32'd1 : 32'd0;
      5'b00011: return (a < b) ? 32'd1 : 32'd0;
      5'b00100: return a ^ b;
      5'b00110: return a | b;
      5'b00111: return a & b;
      5'b11000: f = (a == b);
      5'b11001: f = (a != b);
      5'b11100: f = (sa < sbv);
      5'b11101: f = (sa >= sbv);
      5'b11110: f = (a < b);
      5'b11111: f = (a >= b);
      default:  return 32'd0;
    endcase
    return {31'd0, f};
  endfunction

  // Walk the program image with an ISA model and queue one record per instruction.
  task automatic build_expect();
    logic [31:0] m_rf [32];
    logic [7:0]  m_pc;
    logic [31:0] m_out, ins, res;
    logic        f, tk;
    exp_t        e;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pc  = '0;
    m_out = '0;
    for (int step = 0; step < 500; step++) begin
      ins = imem[m_pc];
      res = m_alu(ins[27:23], m_rf[ins[22:18]], m_rf[ins[17:13]], f);
      tk  = ins[31] | (ins[30] & f);
      e.pc      = m_pc;
      e.next_pc = tk ? m_pc + ins[12:5] : m_pc + 8'd1;
      e.lat     = 2;
      e.waits   = 0;
      e.halt    = tk && (ins[12:5] == 8'd0);
      case (ins[29:28])
        2'b01: begin
          if (ins[4:0] != 0) m_rf[ins[4:0]] = res;
          m_out = res;
        end
        2'b10: if (ins[4:0] != 0) m_rf[ins[4:0]] = {{24{ins[12]}}, ins[12:5]};
        2'b00: begin
`ifdef COBRA_IN_PORT_EN
          if (ins[4:0] != 0) m_rf[ins[4:0]] = IN_WORD;
          e.lat     = 2 + IN_WAIT;
          e.waits   = IN_WAIT;
          e.next_pc = m_pc + 8'd1;
          e.halt    = 1'b0;
`endif
        end
        default: ;
      endcase
      e.out = m_out;
      exp_q.push_back(e);
      if (e.halt) begin
        halt_pc = m_pc;
        break;
      end
      m_pc = e.next_pc;
    end
  endtask

  // ALU sweep: op, ra1, ra2, wa
  logic [4:0] t_op  [15] = '{5'b01000, 5'b01101, 5'b00101, 5'b00011, 5'b00010, 5'b00100, 5'b11111,
                             5'b00001, 5'b00111, 5'b00110, 5'b11000, 5'b11001, 5'b11101, 5'b11110,
                             5'b01001};
  logic [4:0] t_ra1 [15] = '{5'd1, 5'd2, 5'd2, 5'd1, 5'd1, 5'd1, 5'd6, 5'd2, 5'd1, 5'd1, 5'd1, 5'd1,
                             5'd2, 5'd1, 5'd1};
  logic [4:0] t_ra2 [15] = '{5'd2, 5'd9, 5'd9, 5'd2, 5'd2, 5'd2, 5'd1, 5'd1, 5'd2, 5'd9, 5'd1, 5'd1,
                             5'd1, 5'd6, 5'd1};
  logic [4:0] t_wa  [15] = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd18, 5'd19, 5'd22, 5'd23,
                             5'd24, 5'd25, 5'd26, 5'd27, 5'd28};

  task automatic load_program();
    int a;
    for (int i = 0; i < 256; i++) imem[i] = '0;
    imem[0]   = enc(1'b0, 1'b1, 2'b11, 5'b11000, 5'd20, 5'd0, 8'd2, 5'd0);
    imem[1]   = enc(1'b1, 1'b0, 2'b11, 5'b00000, 5'd0, 5'd0, 8'hFC, 5'd0);
    imem[2]   = enc(1'b0, 1'b0, 2'b10, 5'b00000, 5'd0, 5'd0, 8'd5, 5'd1);
    imem[3]   = enc(1'b0, 1'b0, 2'b10, 5'b00000, 5'd0, 5'd0, 8'hFD, 5'd2);
    imem[4]   = enc(1'b0, 1'b0, 2'b01, 5'b00000, 5'd1, 5'd2, 8'd0, 5'd3);
    imem[5]   = enc(1'b0, 1'b0, 2'b01, 5'b00000, 5'd1, 5'd1, 8'd0, 5'd0);
    imem[6]   = enc(1'b0, 1'b0, 2'b01, 5'b00000, 5'd0, 5'd1, 8'd0, 5'd5);
    imem[7]   = enc(1'b0, 1'b0, 2'b10, 5'b00000, 5'd0, 5'd0, 8'hFF, 5'd6);
    imem[8]   = enc(1'b0, 1'b0, 2'b10, 5'b00000, 5'd0, 5'd0, 8'd1, 5'd9);
    imem[9]   = enc(1'b1, 1'b0, 2'b11, 5'b00000, 5'd0, 5'd0, 8'd3, 5'd0);
    imem[10]  = enc(1'b1, 1'b0, 2'b11, 5'b00000, 5'd0, 5'd0, 8'd4, 5'd0);
    imem[12]  = enc(1'b0, 1'b1, 2'b01, 5'b11100, 5'd6, 5'd9, 8'hFE, 5'd10);
    imem[14]  = enc(1'b0, 1'b1, 2'b11, 5'b11100, 5'd9, 5'd6, 8'hFE, 5'd0);
    imem[15]  = enc(1'b1, 1'b1, 2'b01, 5'b11100, 5'd9, 5'd6, 8'd2, 5'd21);
    a = 17;
    for (int i = 0; i < 15; i++) begin
      imem[a] = enc(1'b0, 1'b0, 2'b01, t_op[i], t_ra1[i], t_ra2[i], 8'd0, t_wa[i]);
      a++;
    end
    imem[a]   = enc(1'b0, 1'b0, 2'b00, 5'b00000, 5'd0, 5'd0, 8'd0, 5'd7);
    imem[a+1] = enc(1'b0, 1'b0, 2'b01, 5'b00000, 5'd7, 5'd0, 8'd0, 5'd8);
    imem[a+2] = enc(1'b0, 1'b0, 2'b10, 5'b00000, 5'd0, 5'd0, 8'd9, 5'd4);
    imem[a+3] = enc(1'b0, 1'b0, 2'b10, 5'b00000, 5'd0, 5'd0, 8'd1, 5'd20);
    imem[a+4] = enc(1'b1, 1'b0, 2'b11, 5'b00000, 5'd0, 5'd0, 8'(255 - (a + 4)), 5'd0);
    imem[255] = enc(1'b0, 1'b0, 2'b10, 5'b00000, 5'd0, 5'd0, 8'd3, 5'd17);
    imem[253] = enc(1'b1, 1'b0, 2'b11, 5'b00000, 5'd0, 5'd0, 8'h33, 5'd0);
    imem[48]  = enc(1'b1, 1'b0, 2'b10, 5'b00000, 5'd0, 5'd0, 8'd0, 5'd4);
  endtask

  // Input-port driver: raise in_valid in the wait_target-th WAIT_IN cycle.
  int wait_target = IN_WAIT;
  int wc = 0;
  always @(posedge clk) begin
    #1;
    if (in_ready) begin
      wc++;
      in_valid = (wc == wait_target);
    end else begin
      wc       = 0;
      in_valid = 1'b0;
    end
  end

  // Retire monitor: pops the scoreboard and checks the cycle after each retire.
  int   cnt = 1;
  int   rdy_cnt = 0;
  logic pend = 1'b0;
  exp_t pend_e;
  always @(negedge clk) begin
    if (rst) begin
      cnt     = 1;
      rdy_cnt = 0;
      pend    = 1'b0;
    end else begin
      if (pend) begin
        check("next_pc", 32'(imem_addr), 32'(pend_e.next_pc));
        check("out_data", out_data, pend_e.out);
        check("halted", 32'(halted), 32'(pend_e.halt));
        pend = 1'b0;
      end
      cnt++;
      if (in_ready) rdy_cnt++;
      if (retired) begin
        if (exp_q.size() == 0) begin
          check("spurious_retire", 32'(retired), 32'd0);
        end else begin
          pend_e = exp_q.pop_front();
          check("retire_pc", 32'(imem_addr), 32'(pend_e.pc));
          check("latency", 32'(cnt), 32'(pend_e.lat));
          check("in_ready_cycles", 32'(rdy_cnt), 32'(pend_e.waits));
          pend = 1'b1;
        end
        cnt     = 0;
        rdy_cnt = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = IN_WORD;
    load_program();
    build_expect();

    repeat (2) @(negedge clk);
    check("reset_pc", 32'(imem_addr), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    #2 rst = 1'b0;

    for (int i = 0; i < 2000 && !halted; i++) @(negedge clk);
    check("halt_reached", 32'(halted), 32'd1);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("x4_written_by_halt", dut.rf[4], 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_addr_stable", 32'(imem_addr), 32'(halt_pc));
      check("halt_no_retire", 32'(retired), 32'd0);
    end

    #2 rst = 1'b1;
    #2;
    check("rst_clears_halted", 32'(halted), 32'd0);
    check("rst_clears_pc", 32'(imem_addr), 32'd0);

`ifdef COBRA_IN_PORT_EN
    // Abandon an input instruction in WAIT_IN by resetting.
    wait_target = 1000;
    imem[0] = enc(1'b0, 1'b0, 2'b00, 5'b00000, 5'd0, 5'd0, 8'd0, 5'd7);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    check("wait_in_entered", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #2;
    check("wait_rst_x7_unwritten", dut.rf[7], 32'd0);
    check("wait_rst_pc", 32'(imem_addr), 32'd0);
    check("wait_rst_in_ready", 32'(in_ready), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
